// File: rtl/jk_seq_pkg.sv
// Shared types for the jk_ff bank sequencer: command opcodes and controller states.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop cell with synchronous active-low reset.
module jk_ff (
  input  logic clk,
  input  logic rstn,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rstn)        q <= 1'b0;
    else if (j && k)  q <= ~q;
    else if (j)       q <= 1'b1;
    else if (k)       q <= 1'b0;
  end

endmodule

// File: rtl/jk_toggle_gen.sv
// Toggle mask for a ripple up/down count on a jk_ff bank, plus the wrap indicator.
module jk_toggle_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_t,
  output logic             o_wrap
);

  logic [WIDTH-1:0] w_m;
  logic             w_acc;

  // Counting down is counting up on the inverted value.
  assign w_m    = i_down ? ~i_q : i_q;
  assign o_wrap = &w_m;

  always_comb begin
    o_t   = '0;
    w_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      o_t[i] = w_acc;
      w_acc  = w_acc & w_m[i];
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving the j/k inputs of an external jk_ff bank.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             pause,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_e           r_state, w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rem;
  logic             r_tc;

  logic             w_accept;
  logic             w_cnt_op;
  logic             w_in_cnt;
  logic             w_step;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap;

  jk_toggle_gen #(.WIDTH(WIDTH)) u_tgen (
    .i_q    (q),
    .i_down (r_op == OP_DOWN),
    .o_t    (w_t),
    .o_wrap (w_wrap)
  );

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign tc        = r_tc;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_in_cnt  = cmd_op[1];
  assign w_cnt_op  = (r_op == OP_UP) || (r_op == OP_DOWN);
  // Pause only stalls counting runs; CLEAR/LOAD always complete in one edge.
  assign w_step    = (r_state == S_RUN) && (!w_cnt_op || !pause);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_op    <= OP_CLEAR;
      r_data  <= '0;
      r_rem   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op_e'(cmd_op);
        r_data <= cmd_data;
        r_tc   <= 1'b0;
        r_rem  <= w_in_cnt ? cmd_data : WIDTH'(1);
      end else if (w_step) begin
        r_rem <= r_rem - WIDTH'(1);
        if (w_cnt_op && w_wrap) r_tc <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = (w_in_cnt && cmd_data == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_step && r_rem == WIDTH'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    j = '0;
    k = '0;
    if (r_state == S_RUN) begin
      unique case (r_op)
        OP_CLEAR: k = '1;
        OP_LOAD: begin
          j = r_data;
          k = ~r_data;
        end
        OP_UP, OP_DOWN: if (!pause) begin
          j = w_t;
          k = w_t;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Randomized self-checking bench for jk_seq_ctrl driving a 4-bit jk_ff bank.
module tb_jk_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         pause;
  logic [W-1:0] q;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         busy;
  logic         done;
  logic         tc;

  int n_chk = 0;
  int n_err = 0;
  int m_q   = 0;
  bit m_tc  = 1'b0;

  always #5 clk = ~clk;

  jk_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pause(pause), .q(q),
    .j(j), .k(k), .busy(busy), .done(done), .tc(tc)
  );

  for (genvar g = 0; g < W; g++) begin : g_bank
    jk_ff u_ff (.clk(clk), .rstn(rstn), .j(j[g]), .k(k[g]), .q(q[g]));
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: the register as an integer modulo 16.
  task automatic model_step(input int op, input int data);
    case (op)
      0: m_q = 0;
      1: m_q = data;
      2: begin if (m_q == 15) m_tc = 1'b1; m_q = (m_q + 1) % 16; end
      default: begin if (m_q == 0) m_tc = 1'b1; m_q = (m_q + 15) % 16; end
    endcase
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause for 4 cycles after first step.
  task automatic do_cmd(input int op, input int data, input int pmode,
                        input bit noisy, input bit chain);
    int guard, steps, cyc, pcnt, nsteps;
    bit p;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_data = data[W-1:0];
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    steps = (op >= 2) ? data : 1;
    m_tc = 1'b0; cyc = 0; pcnt = 0; nsteps = 0;
    while (steps > 0 && cyc < 100) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      p = 1'b0;
      if (pmode == 1)      p = ($urandom_range(0, 3) == 0);
      else if (pmode == 2) p = (nsteps == 1 && pcnt < 4);
      pause = p;
      if (noisy) begin
        cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_data = W'($urandom);
      end
      #1;
      if (op >= 2 && p) chk("jk_paused", {j, k}, 0);
      else if (op < 2)  chk("jk_not_both", j & k, 0);
      @(posedge clk); @(negedge clk);
      cyc++;
      if (op < 2 || !p) begin
        model_step(op, data); steps--; nsteps++;
        chk("q_step", q, m_q);
      end else begin
        pcnt++;
        chk("q_hold", q, m_q);
      end
    end
    pause = 1'b0;
    cmd_valid = 1'b0;
    chk("done", done, 1);
    chk("tc", tc, m_tc);
    chk("q_final", q, m_q);
    chk("ready_in_done", cmd_ready, 0);
    if (pmode == 2) chk("run_cycles", cyc, 7);
    if (chain) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = W'($urandom);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("ready_idle", cmd_ready, 1);
    chk("jk_idle", {j, k}, 0);
  endtask

  initial begin
    int op, data;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; pause = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_jk", {j, k}, 0);
    rstn = 1'b1;
    @(negedge clk);

    do_cmd(1, 4'hA, 0, 0, 0);
    do_cmd(1, 4'hD, 0, 0, 0);
    do_cmd(2, 5, 0, 0, 0);
    chk("up5_q", q, 4'h2);
    do_cmd(3, 2, 0, 0, 0);
    chk("down2_q", q, 4'h0);
    do_cmd(3, 1, 0, 0, 0);
    chk("down1_q", q, 4'hF);
    do_cmd(0, 0, 0, 0, 0);
    do_cmd(2, 3, 2, 0, 0);
    chk("up3_pause_q", q, 4'h3);
    do_cmd(2, 0, 0, 1, 0);
    chk("up0_q", q, 4'h3);

    // CLEAR held valid through DONE is picked up at the first IDLE edge.
    do_cmd(1, 4'h9, 0, 0, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("chain_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    m_q = 0;
    chk("chain_q", q, 0);
    chk("chain_done", done, 1);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 3));
      data = int'($urandom_range(0, 15));
      do_cmd(op, data, 1, 1'($urandom), 0);
    end

    // Reset mid-run abandons the command with no done pulse.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'd10;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      model_step(2, 10);
      chk("mid_q", q, m_q);
    end
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    m_q = 0;
    chk("mrst_q", q, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_tc", tc, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_done", done, 0);
    end
    do_cmd(1, 4'h6, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
